// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI responder (mode 0, MSB first); `SPI_SLAVE_SYNC_EN adds 2-FF input synchronizers
module spi_slave #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic              miso_o,
  output logic              miso_en_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o,
  output logic              abort_o
);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  logic sclk_w, cs_w, mosi_w;
`ifdef SPI_SLAVE_SYNC_EN
  logic [1:0] sclk_s_q, cs_s_q, mosi_s_q;
  // two-stage synchronizers for an asynchronous master
  always_ff @(posedge clk)
    if (!reset_n) begin
      sclk_s_q <= 2'b00;
      cs_s_q   <= 2'b11;
      mosi_s_q <= 2'b00;
    end else begin
      sclk_s_q <= {sclk_s_q[0], sclk_i};
      cs_s_q   <= {cs_s_q[0], cs_n_i};
      mosi_s_q <= {mosi_s_q[0], mosi_i};
    end
  assign sclk_w = sclk_s_q[1];
  assign cs_w   = cs_s_q[1];
  assign mosi_w = mosi_s_q[1];
`else
  assign sclk_w = sclk_i;
  assign cs_w   = cs_n_i;
  assign mosi_w = mosi_i;
`endif
  state_t            state_q;
  logic              sclk_q, cs_q, reload_q;
  logic              rx_valid_q, abort_q, busy_q, miso_en_q;
  logic [CW-1:0]     bit_cnt_q;
  logic [DATA_W-1:0] tx_shift_q, rx_shift_q, rx_data_q;
  logic              rise, fall, sel;
  assign rise = sclk_w & ~sclk_q;
  assign fall = ~sclk_w & sclk_q;
  assign sel  = ~cs_w & cs_q;
  // framing FSM: shift in on sclk rise, shift out on sclk fall, reload tx after each full byte
  always_ff @(posedge clk)
    if (!reset_n) begin
      state_q    <= IDLE;
      sclk_q     <= 1'b0;
      cs_q       <= 1'b1;
      reload_q   <= 1'b0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
      miso_en_q  <= 1'b0;
    end else begin
      sclk_q     <= sclk_w;
      cs_q       <= cs_w;
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
      if (state_q == IDLE) begin
        tx_shift_q <= tx_data_i;
        if (sel) begin
          state_q   <= SHIFT;
          busy_q    <= 1'b1;
          miso_en_q <= 1'b1;
          bit_cnt_q <= '0;
          reload_q  <= 1'b0;
        end
      end else if (cs_w) begin
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        miso_en_q <= 1'b0;
        abort_q   <= bit_cnt_q != '0;
      end else if (rise) begin
        rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_w};
        if (bit_cnt_q == CW'(DATA_W - 1)) begin
          rx_data_q  <= {rx_shift_q[DATA_W-2:0], mosi_w};
          rx_valid_q <= 1'b1;
          bit_cnt_q  <= '0;
          reload_q   <= 1'b1;
        end else
          bit_cnt_q <= bit_cnt_q + 1'b1;
      end else if (fall) begin
        tx_shift_q <= reload_q ? tx_data_i : {tx_shift_q[DATA_W-2:0], 1'b0};
        reload_q   <= 1'b0;
      end
    end
  assign miso_o     = tx_shift_q[DATA_W-1];
  assign miso_en_o  = miso_en_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = busy_q;
  assign abort_o    = abort_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master with a receive scoreboard for spi_slave
module tb_spi_slave;
`ifdef SPI_SLAVE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int H = 5;
  logic clk = 0, reset_n = 0, sclk = 0, cs_n = 1, mosi = 0;
  logic [7:0] tx_data = 8'h3C;
  logic miso, miso_en, rx_valid, busy, abort;
  logic [7:0] rx_data;
  int n_chk = 0, n_err = 0, rv_cnt = 0, ab_cnt = 0, cyc = 0, last_rise = 0, rv0, ab0;
  logic [7:0] exp_q[$];
  logic [7:0] got, got2;
  spi_slave #(.DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .sclk_i(sclk), .cs_n_i(cs_n), .mosi_i(mosi),
    .tx_data_i(tx_data), .miso_o(miso), .miso_en_o(miso_en), .rx_data_o(rx_data),
    .rx_valid_o(rx_valid), .busy_o(busy), .abort_o(abort)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input int nb, input logic [7:0] nxt, output logic [7:0] g);
    g = '0;
    for (int i = 0; i < nb; i++) begin
      mosi = d[7-i];
      repeat (H) tick();
      g = {g[6:0], miso};
      sclk = 1;
      last_rise = cyc;
      if (i == 7) begin
        repeat (LAT + 1) tick();
        tx_data = nxt;
        repeat (H - LAT - 1) tick();
      end else
        repeat (H) tick();
      sclk = 0;
    end
    repeat (H) tick();
  endtask
  always @(negedge clk) begin
    if (abort) ab_cnt++;
    if (rx_valid) begin
      rv_cnt++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $error("FAIL unexpected_rx_valid observed=%0h expected=none", rx_data);
      end else begin
        check("rx_data", rx_data, exp_q.pop_front());
        check("rx_latency", cyc - last_rise, LAT);
      end
    end
  end
  initial begin
    repeat (3) tick();
    check("rst_miso", miso, 0);
    check("rst_miso_en", miso_en, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_abort", abort, 0);
    reset_n = 1;
    repeat (4) tick();
    rv0 = rv_cnt;
    cs_n = 0;
    exp_q.push_back(8'hA5);
    repeat (LAT) tick();
    check("sel_busy", busy, 1);
    check("sel_miso_en", miso_en, 1);
    check("sel_miso_msb", miso, 0);
    send(8'hA5, 8, 8'h3C, got);
    check("t1_miso_byte", got, 8'h3C);
    check("t1_busy_before_cs", busy, 1);
    cs_n = 1;
    repeat (LAT) tick();
    check("t1_busy_fall", busy, 0);
    check("t1_rx_data", rx_data, 8'hA5);
    check("t1_rv_pulses", rv_cnt - rv0, 1);
    tx_data = 8'h81;
    repeat (4) tick();
    rv0 = rv_cnt;
    cs_n = 0;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send(8'h12, 8, 8'h7E, got);
    send(8'h34, 8, 8'h7E, got2);
    cs_n = 1;
    repeat (LAT + 1) tick();
    check("t2_miso_byte0", got, 8'h81);
    check("t2_miso_byte1", got2, 8'h7E);
    check("t2_rv_pulses", rv_cnt - rv0, 2);
    rv0 = rv_cnt;
    ab0 = ab_cnt;
    cs_n = 0;
    send(8'hE0, 3, 8'h7E, got);
    cs_n = 1;
    repeat (LAT) tick();
    check("t3_abort_pulse", abort, 1);
    check("t3_busy", busy, 0);
    tick();
    check("t3_abort_clear", abort, 0);
    check("t3_abort_cnt", ab_cnt - ab0, 1);
    check("t3_no_rv", rv_cnt - rv0, 0);
    check("t3_rx_hold", rx_data, 8'h34);
    repeat (3) tick();
    cs_n = 0;
    exp_q.push_back(8'hFF);
    send(8'hFF, 8, 8'h7E, got);
    cs_n = 1;
    repeat (LAT + 1) tick();
    check("t3_ff_rx", rx_data, 8'hFF);
    check("t3_ff_miso", got, 8'h7E);
    rv0 = rv_cnt;
    ab0 = ab_cnt;
    cs_n = 0;
    send(8'h5A, 4, 8'h7E, got);
    reset_n = 0;
    tick();
    check("t4_miso", miso, 0);
    check("t4_miso_en", miso_en, 0);
    check("t4_rx_data", rx_data, 0);
    check("t4_busy", busy, 0);
    reset_n = 1;
    cs_n = 1;
    repeat (LAT + 3) tick();
    check("t4_no_rv", rv_cnt - rv0, 0);
    check("t4_no_abort", ab_cnt - ab0, 0);
    cs_n = 0;
    exp_q.push_back(8'h00);
    send(8'h00, 8, 8'h7E, got);
    cs_n = 1;
    repeat (LAT + 1) tick();
    check("t4_rx_00", rx_data, 8'h00);
    check("t4_rv_pulses", rv_cnt - rv0, 1);
    rv0 = rv_cnt;
    ab0 = ab_cnt;
    tx_data = 8'hB7;
    for (int i = 0; i < 3; i++) begin
      sclk = 1;
      repeat (H) tick();
      sclk = 0;
      repeat (H) tick();
    end
    check("t5_miso_en", miso_en, 0);
    check("t5_miso", miso, 1);
    check("t5_busy", busy, 0);
    check("t5_no_rv", rv_cnt - rv0, 0);
    check("t5_no_abort", ab_cnt - ab0, 0);
    tx_data = 8'h5A;
    cs_n = 0;
    exp_q.push_back(8'hC3);
    send(8'hC3, 8, 8'h5A, got);
    cs_n = 1;
    repeat (LAT + 1) tick();
    check("t6_rx_c3", rx_data, 8'hC3);
    check("t6_miso_byte", got, 8'h5A);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
